// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the FND (7-segment) scan controller:
//   - active-low segment patterns for digits 0..9 and the all-off pattern
//   - decimal-point bit position inside the 8-bit segment word
//   - seg_encode(): BCD nibble -> active-low segment word (dp off)
//   - pow10(): constant helper used to size the saturation limit
// Segment word layout: bit 7 = dp, bits 6:0 = g..a, all active-low.
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam int DP_BIT = 7;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Non-decimal nibbles never occur after double dabble; they map to off.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// -----------------------------------------------------------------------------
// fnd_bin2bcd
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// The input is saturated to 10^NUM_DIGITS-1 when captured.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a conversion)
//   start      capture request, honoured only while idle
//   bin        binary value to convert
//   busy       high for exactly DATA_W cycles after a captured start
//   done       high during the final conversion cycle; bcd is valid then
//   bcd        finished BCD result (meaningful only while done=1)
// -----------------------------------------------------------------------------
module fnd_bin2bcd
    import fnd_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  work_q,  work_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [DATA_W-1:0] sat_s;

    // Saturate the captured value so it always fits in NUM_DIGITS decimals.
    always_comb begin
        sat_s = bin;
        if (64'(bin) > MAX_VAL) begin
            sat_s = MAX_VAL[DATA_W-1:0];
        end else begin
            sat_s = bin;
        end
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
    always_comb begin
        logic [BCD_W-1:0] adj;
        adj = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        work_d  = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
        shift_d = shift_q << 1;
    end

    // Conversion state: capture when idle, step while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (!busy_q) begin
            if (start) begin
                shift_q <= sat_s;
                work_q  <= '0;
                cnt_q   <= CNT_W'(DATA_W);
                busy_q  <= 1'b1;
            end
        end else begin
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The last step's result is handed out combinationally so the display
    // can commit on the same edge that ends busy.
    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(1));
    assign bcd  = work_d;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
// Multi-digit active-low 7-segment scan controller with per-digit dp,
// leading-zero blanking and PWM brightness.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bin_in      value to display (saturated to NUM_DIGITS decimals)
//   load        single-cycle capture request, ignored while busy
//   dot_mask    per-digit decimal point enable (bit 0 = rightmost), live
//   blank_lz    leading-zero blanking enable, live
//   bright      PWM duty level, live
//   busy        conversion in progress
//   fnd_digit   active-low digit enables (registered)
//   fnd_data    active-low segments, bit 7 = dp (registered)
// -----------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     bin_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dot_mask,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] fnd_digit,
    output logic [7:0]            fnd_data
);

    localparam int P      = CLK_HZ / SCAN_HZ;
    localparam int SLOT_W = (P > 1) ? $clog2(P) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W  = 4 * NUM_DIGITS;

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q,  idx_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic [7:0]            data_q,  data_d;

    logic                  conv_done_s;
    logic [BCD_W-1:0]      conv_bcd_s;
    logic [31:0]           thr_s;
    logic                  lit_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic [3:0]            nib_s;

    fnd_bin2bcd #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (bin_in),
        .busy  (busy),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Free-running slot counter and scan index; display commits atomically.
    always_comb begin
        slot_d = slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        if (slot_q == SLOT_W'(P - 1)) begin
            slot_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
        if (conv_done_s) begin
            disp_d = conv_bcd_s;
        end else begin
            disp_d = disp_q;
        end
    end

    // PWM window; count 0 of each slot stays dark so segment data never
    // changes under an enabled digit.
    always_comb begin
        thr_s = ((32'(bright) + 32'd1) * 32'(P)) >> BRIGHT_W;
        lit_s = (slot_q != '0) && (32'(slot_q) < thr_s);
    end

    // A digit is a leading zero when it and every digit to its left are 0.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank_s  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_q[4*i +: 4] == 4'd0);
            blank_s[i] = blank_lz && (i != 0) && zero_run;
        end
    end

    // Next output word for the active digit.
    always_comb begin
        nib_s   = disp_q[{idx_q, 2'b00} +: 4];
        digit_d = '1;
        data_d  = SEG_OFF;
        if (lit_s) begin
            digit_d = ~(NUM_DIGITS'(1) << idx_q);
            if (blank_s[idx_q]) begin
                data_d = SEG_OFF;
            end else begin
                data_d = seg_encode(nib_s);
            end
            if (dot_mask[idx_q]) begin
                data_d[DP_BIT] = 1'b0;
            end else begin
                data_d[DP_BIT] = data_d[DP_BIT];
            end
        end else begin
            digit_d = '1;
            data_d  = SEG_OFF;
        end
    end

    // Counters, display registers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            digit_q <= '1;
            data_q  <= SEG_OFF;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            digit_q <= digit_d;
            data_q  <= data_d;
        end
    end

    assign fnd_digit = digit_q;
    assign fnd_data  = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

    localparam int N  = 4;
    localparam int DW = 14;
    localparam int P  = 10;
    localparam int BW = 3;

    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam int P10 [5] = '{1, 10, 100, 1000, 10000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] bin_in = '0;
    logic          load = 1'b0;
    logic [N-1:0]  dot_mask = '0;
    logic          blank_lz = 1'b0;
    logic [BW-1:0] bright = 3'd7;
    logic          busy;
    logic [N-1:0]  fnd_digit;
    logic [7:0]    fnd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int k_cyc = 0;      // edges since reset released
    int exp_disp = 0;   // value the display should hold

    fnd_scan_ctrl #(
        .NUM_DIGITS (N),
        .DATA_W     (DW),
        .CLK_HZ     (1000),
        .SCAN_HZ    (100),
        .BRIGHT_W   (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .load      (load),
        .dot_mask  (dot_mask),
        .blank_lz  (blank_lz),
        .bright    (bright),
        .busy      (busy),
        .fnd_digit (fnd_digit),
        .fnd_data  (fnd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k_cyc <= 0;
        else     k_cyc <= k_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Reference: what the pins show kk edges after reset, for a steady
    // display value and steady live inputs.
    function automatic void model_out(input int kk, input int disp, input logic [N-1:0] dm,
                                      input logic blz, input int br,
                                      output logic [N-1:0] dg, output logic [7:0] dt);
        int prev, cnt, idx, thr, dval;
        logic blank;
        dg = '1;
        dt = 8'hFF;
        if (kk > 0) begin
            prev = kk - 1;
            cnt  = prev % P;
            idx  = (prev / P) % N;
            thr  = ((br + 1) * P) >> BW;
            if (cnt != 0 && cnt < thr) begin
                dg    = 4'hF & ~(4'd1 << idx);
                dval  = (disp / P10[idx]) % 10;
                blank = blz && (idx > 0) && (disp < P10[idx]);
                dt    = blank ? 8'hFF : SEG_TAB[dval];
                if (dm[idx]) dt[7] = 1'b0;
            end
        end
    endfunction

    // Issue a load and count busy cycles (bounded).
    task automatic do_load(input int v, output int nb);
        load   = 1'b1;
        bin_in = DW'(v);
        @(posedge clk); #1;
        load = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            @(posedge clk); #1;
        end
    endtask

    task automatic verify_scan(input int ncyc, input string tag);
        logic [N-1:0] edg;
        logic [7:0]   edt;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            model_out(k_cyc, exp_disp, dot_mask, blank_lz, int'(bright), edg, edt);
            n_cmp++;
            if (fnd_digit !== edg || fnd_data !== edt) begin
                n_bad++;
                $display("FAIL %s k=%0d: got digit=%b data=%h, expected digit=%b data=%h",
                         tag, k_cyc, fnd_digit, fnd_data, edg, edt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || fnd_digit !== 4'hF || fnd_data !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset: got busy=%b digit=%h data=%h, expected 0/F/FF", busy, fnd_digit, fnd_data);
        end
        rst = 1'b0;
        exp_disp = 0;
        verify_scan(N * P, "reset_zero");
    endtask

    task automatic test_load_1234();
        int nb;
        bright = 3'd7; blank_lz = 1'b0; dot_mask = 4'b0000;
        do_load(1234, nb);
        n_cmp++;
        if (nb !== DW) begin
            n_bad++;
            $display("FAIL busy_len_1234: got %0d cycles, expected %0d", nb, DW);
        end
        exp_disp = 1234;
        verify_scan(2 * N * P, "scan_1234");
    endtask

    task automatic test_blank();
        int nb;
        blank_lz = 1'b1; dot_mask = 4'b0100;
        do_load(7, nb);
        n_cmp++;
        if (nb !== DW) begin
            n_bad++;
            $display("FAIL busy_len_7: got %0d cycles, expected %0d", nb, DW);
        end
        exp_disp = 7;
        verify_scan(N * P, "blank_7");
        blank_lz = 1'b0; dot_mask = 4'b0000;
    endtask

    task automatic test_saturate();
        int nb;
        do_load(16383, nb);
        exp_disp = 9999;
        verify_scan(N * P, "saturate");
    endtask

    task automatic test_bright();
        bright = 3'd0;
        verify_scan(N * P, "bright0");
        bright = 3'd3;
        verify_scan(N * P, "bright3");
        bright = 3'd7;
    endtask

    task automatic test_ignore_busy();
        int nb;
        load = 1'b1; bin_in = 14'd42;
        @(posedge clk); #1;
        load = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            if (nb == 5) begin
                load = 1'b1; bin_in = 14'd99;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        n_cmp++;
        if (nb !== DW) begin
            n_bad++;
            $display("FAIL busy_len_ignore: got %0d cycles, expected %0d", nb, DW);
        end
        exp_disp = 42;
        verify_scan(N * P, "ignore_busy");
    endtask

    task automatic test_rst_mid();
        int nb;
        load = 1'b1; bin_in = DW'($urandom_range(1, 9999));
        @(posedge clk); #1;
        load = 1'b0;
        nb = 0;
        while (busy && nb < 7) begin
            nb++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || fnd_digit !== 4'hF || fnd_data !== 8'hFF) begin
            n_bad++;
            $display("FAIL rst_mid: got busy=%b digit=%h data=%h, expected 0/F/FF", busy, fnd_digit, fnd_data);
        end
        exp_disp = 0;
        verify_scan(N * P, "after_rst_mid");
        // reset wins over a simultaneous load
        rst = 1'b1; load = 1'b1; bin_in = 14'd1234;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_vs_load: got busy=%b, expected 0", busy);
        end
        verify_scan(N * P, "after_rst_load");
    endtask

    task automatic test_back_to_back();
        int nb1, nb2;
        do_load(5678, nb1);
        do_load(901, nb2);
        n_cmp++;
        if (nb1 !== DW || nb2 !== DW) begin
            n_bad++;
            $display("FAIL back_to_back: got busy %0d/%0d cycles, expected %0d/%0d", nb1, nb2, DW, DW);
        end
        exp_disp = 901;
        verify_scan(N * P, "back_to_back");
    endtask

    task automatic test_random();
        int v, nb, newv;
        logic [N-1:0] edg;
        logic [7:0]   edt;
        for (int it = 0; it < 8; it++) begin
            v        = $urandom_range(0, 16383);
            newv     = (v > 9999) ? 9999 : v;
            dot_mask = N'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            bright   = BW'($urandom_range(0, 7));
            @(posedge clk); #1;
            load = 1'b1; bin_in = DW'(v);
            @(posedge clk); #1;
            load = 1'b0;
            nb = 0;
            // old value must stay on the pins until the commit takes effect
            while (nb < 200) begin
                model_out(k_cyc, exp_disp, dot_mask, blank_lz, int'(bright), edg, edt);
                n_cmp++;
                if (fnd_digit !== edg || fnd_data !== edt) begin
                    n_bad++;
                    $display("FAIL rand_hold it=%0d k=%0d: got digit=%b data=%h, expected digit=%b data=%h",
                             it, k_cyc, fnd_digit, fnd_data, edg, edt);
                end
                if (!busy) break;
                nb++;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (nb !== DW) begin
                n_bad++;
                $display("FAIL rand_busy it=%0d: got %0d cycles, expected %0d", it, nb, DW);
            end
            exp_disp = newv;
            verify_scan(3 * P, "rand_scan");
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_blank();
        test_saturate();
        test_bright();
        test_ignore_busy();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
